// File: rtl/user_irq_ctrl_if.sv
// Register-port interface between the SoC address decoder and the interrupt controller.
// A single request/response handshake: valid with addr/wdata/wstrb in, one-cycle ready with rdata out.
interface nmi_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);
    modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
endinterface

// File: rtl/user_irq_ctrl.sv
// 32-line interrupt controller in front of the core irq_i: synchronise, polarity, edge/level
// capture into pending, and mask with enable; programmed through an nmi register port.
module user_irq_ctrl #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] irq_raw_i,
    nmi_if.slave        nmi,
    output logic [31:0] irq_o
);

    localparam int unsigned W  = 32;
    localparam int unsigned NB = W / 8;

    localparam logic [2:0] A_ENABLE   = 3'd0;
    localparam logic [2:0] A_MODE     = 3'd1;
    localparam logic [2:0] A_PENDING  = 3'd2;
    localparam logic [2:0] A_RAW      = 3'd3;
    localparam logic [2:0] A_POLARITY = 3'd4;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_access;
    logic           w_wr;
    logic           w_rd;
    logic [2:0]     w_idx;
    logic [W-1:0]   w_bmask;
    logic [W-1:0]   w_act;
    logic [W-1:0]   w_set;
    logic [W-1:0]   w_clr;
    logic [W-1:0]   w_pending_nxt;
    logic [W-1:0]   w_rd_mux;
    logic           w_unused_addr;

    logic [W-1:0]   r_sync [SYNC_STAGES];
    logic [W-1:0]   r_act_q;
    logic [W-1:0]   r_enable;
    logic [W-1:0]   r_mode;
    logic [W-1:0]   r_pending;
    logic [W-1:0]   r_polarity;
    logic [W-1:0]   r_rdata;

    assign w_idx         = nmi.addr[4:2];
    assign w_unused_addr = &{1'b0, nmi.addr[31:5], nmi.addr[1:0]};

    // Bus FSM: accept in IDLE, present ready for exactly one cycle in RESP.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (nmi.valid) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_wr      = w_access && (nmi.wstrb != 4'h0);
    assign w_rd      = w_access && (nmi.wstrb == 4'h0);
    assign nmi.ready = (r_state == S_RESP);
    assign nmi.rdata = r_rdata;

    always_comb begin
        w_bmask = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            w_bmask[8*b +: 8] = {8{nmi.wstrb[b]}};
        end
    end

    // Synchroniser chain, then polarity applied on the synchronised level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_act_q <= '0;
        end else begin
            r_sync[0] <= irq_raw_i;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_act_q <= w_act;
        end
    end

    assign w_act = r_sync[SYNC_STAGES-1] ^ r_polarity;
    assign w_set = w_act & ~r_act_q;
    assign w_clr = (w_wr && (w_idx == A_PENDING)) ? (nmi.wdata & w_bmask) : '0;

    // Edge lines: set beats a same-cycle clear. Level lines just follow act.
    assign w_pending_nxt = (r_mode & (w_set | (r_pending & ~w_clr))) | (~r_mode & w_act);

    always_comb begin
        w_rd_mux = '0;
        case (w_idx)
            A_ENABLE:   w_rd_mux = r_enable;
            A_MODE:     w_rd_mux = r_mode;
            A_PENDING:  w_rd_mux = r_pending;
            A_RAW:      w_rd_mux = w_act;
            A_POLARITY: w_rd_mux = r_polarity;
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_enable   <= '0;
            r_mode     <= '0;
            r_pending  <= '0;
            r_polarity <= '0;
            r_rdata    <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_wr && (w_idx == A_ENABLE))
                r_enable <= (r_enable & ~w_bmask) | (nmi.wdata & w_bmask);
            if (w_wr && (w_idx == A_MODE))
                r_mode <= (r_mode & ~w_bmask) | (nmi.wdata & w_bmask);
            if (w_wr && (w_idx == A_POLARITY))
                r_polarity <= (r_polarity & ~w_bmask) | (nmi.wdata & w_bmask);
            if (w_rd)
                r_rdata <= w_rd_mux;
        end
    end

    assign irq_o = r_pending & r_enable;

endmodule

// File: tb/tb_user_irq_ctrl.sv
// Directed bench for user_irq_ctrl: reset, level/edge capture, W1C, polarity and bus handshake.
module tb_user_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] irq_raw;
    logic [31:0] irq_o;
    logic [31:0] rd;
    int          n_checks;
    int          n_fail;

    nmi_if u_nmi ();

    user_irq_ctrl #(.SYNC_STAGES(2)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .irq_raw_i (irq_raw),
        .nmi       (u_nmi),
        .irq_o     (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        u_nmi.valid = 1'b1;
        u_nmi.addr  = addr;
        u_nmi.wdata = data;
        u_nmi.wstrb = strb;
        @(posedge clk);
        #1;
        check("wr_ready", {31'd0, u_nmi.ready}, 32'd1);
        @(negedge clk);
        u_nmi.valid = 1'b0;
        u_nmi.wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        u_nmi.valid = 1'b1;
        u_nmi.addr  = addr;
        u_nmi.wstrb = 4'h0;
        @(posedge clk);
        #1;
        check("rd_ready", {31'd0, u_nmi.ready}, 32'd1);
        data = u_nmi.rdata;
        @(negedge clk);
        u_nmi.valid = 1'b0;
    endtask

    task automatic tick_check_irq(input string tag, input logic [31:0] exp);
        @(posedge clk);
        #1;
        check(tag, irq_o, exp);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        irq_raw     = $urandom;
        u_nmi.valid = 1'b0;
        u_nmi.addr  = '0;
        u_nmi.wdata = '0;
        u_nmi.wstrb = '0;

        // Reset with random raw lines
        repeat (4) @(posedge clk);
        #1;
        check("rst_irq_o", irq_o, 32'h0);
        check("rst_ready", {31'd0, u_nmi.ready}, 32'd0);
        @(negedge clk);
        irq_raw = '0;
        rst_n   = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus_read(32'(a * 4), rd);
            check($sformatf("rst_reg_%0h", a * 4), rd, 32'h0);
        end

        // Level path on line 0
        bus_write(32'h00, 32'h1, 4'hF);
        bus_write(32'h04, 32'h0, 4'hF);
        @(negedge clk);
        irq_raw = 32'h1;
        tick_check_irq("lvl_rise_k",  32'h0);
        tick_check_irq("lvl_rise_k1", 32'h0);
        tick_check_irq("lvl_rise_k2", 32'h1);
        @(negedge clk);
        irq_raw = 32'h0;
        tick_check_irq("lvl_fall_k",  32'h1);
        tick_check_irq("lvl_fall_k1", 32'h1);
        tick_check_irq("lvl_fall_k2", 32'h0);
        @(negedge clk);
        irq_raw = 32'h1;
        repeat (3) @(posedge clk);
        bus_write(32'h08, 32'h1, 4'hF);
        check("lvl_w1c_noeffect", irq_o, 32'h1);
        bus_read(32'h08, rd);
        check("lvl_pending_rd", rd, 32'h1);
        @(negedge clk);
        irq_raw = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("lvl_idle", irq_o, 32'h0);

        // Edge path on line 1
        bus_write(32'h04, 32'h2, 4'hF);
        bus_write(32'h00, 32'h2, 4'hF);
        @(negedge clk);
        irq_raw = 32'h2;
        @(negedge clk);
        irq_raw = 32'h0;
        tick_check_irq("edge_k1", 32'h0);
        tick_check_irq("edge_k2", 32'h2);
        repeat (4) @(posedge clk);
        #1;
        check("edge_sticky", irq_o, 32'h2);
        bus_write(32'h08, 32'h1, 4'hF);
        check("edge_w1c_other", irq_o, 32'h2);
        bus_write(32'h08, 32'h2, 4'hF);
        check("edge_w1c_clear", irq_o, 32'h0);

        // W1C captured on the same edge as a new set event
        @(negedge clk);
        irq_raw = 32'h2;
        @(posedge clk);
        @(posedge clk);
        bus_write(32'h08, 32'h2, 4'hF);
        check("setclr_irq", irq_o, 32'h2);
        bus_read(32'h08, rd);
        check("setclr_pending", rd, 32'h2);
        bus_write(32'h08, 32'h2, 4'hF);
        check("setclr_then_clear", irq_o, 32'h0);
        @(negedge clk);
        irq_raw = 32'h0;
        repeat (3) @(posedge clk);

        // Active-low line 2 with raw held low
        bus_write(32'h10, 32'h4, 4'hF);
        bus_write(32'h04, 32'h0, 4'hF);
        bus_write(32'h00, 32'h4, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        check("pol_irq", irq_o, 32'h4);
        bus_read(32'h0C, rd);
        check("pol_raw", rd, 32'h4);

        // valid held high across back-to-back writes
        @(negedge clk);
        u_nmi.valid = 1'b1;
        u_nmi.addr  = 32'h00;
        u_nmi.wdata = 32'h4;
        u_nmi.wstrb = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b_ready_%0d", c), {31'd0, u_nmi.ready}, 32'((c + 1) % 2));
        end
        @(negedge clk);
        u_nmi.valid = 1'b0;
        u_nmi.wstrb = 4'h0;

        // Byte-lane strobes, unmapped read, rdata hold across writes
        bus_write(32'h00, 32'h0, 4'hF);
        bus_write(32'h00, 32'hFFFF_FFFF, 4'h2);
        bus_read(32'h00, rd);
        check("strb_enable", rd, 32'h0000_FF00);
        bus_write(32'h10, 32'h0, 4'hF);
        check("rdata_hold", u_nmi.rdata, 32'h0000_FF00);
        bus_read(32'h18, rd);
        check("unmapped_rd", rd, 32'h0);

        // Asynchronous reset during a response
        @(negedge clk);
        u_nmi.valid = 1'b1;
        u_nmi.addr  = 32'h04;
        u_nmi.wdata = 32'hFFFF_FFFF;
        u_nmi.wstrb = 4'hF;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", {31'd0, u_nmi.ready}, 32'd0);
        u_nmi.valid = 1'b0;
        u_nmi.wstrb = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(32'h04, rd);
        check("async_rst_mode", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/user_irq_ctrl.md
# user_irq_ctrl

Interrupt controller that sits directly upstream of the user core's `irq_i` input. It synchronises 32 raw interrupt lines and applies per-line polarity and edge/level mode. It latches pending state and drives the masked result onto `irq_o[31:0]`, which wires straight to the core's `irq_i`. Software programs and services it through a register file on an `nmi` slave port, reached via the SoC address decoder.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth on each raw line; legal range 2..3.
- `clk_i`  input  1  system clock; all logic on the rising edge.
- `rst_n_i`  input  1  reset, asynchronous assert, active-low.
- `irq_raw_i`  input  32  asynchronous raw interrupt sources.
- `nmi`  `nmi_if.slave`  -  register port:
  - `valid`, `addr[31:0]`, `wdata[31:0]`, `wstrb[3:0]` are inputs.
  - `ready`, `rdata[31:0]` are outputs.
- `irq_o`  output  32  masked interrupt vector (`pending & enable`), feeds the core `irq_i`.

## Operation
- Register map is decoded on `addr[4:2]`; upper bits are ignored (the decoder selects the block):
  - 0x00 ENABLE, RW: per-line mask.
  - 0x04 MODE, RW: 1 = edge, 0 = level.
  - 0x08 PENDING: read returns pending; write-1-to-clear, edge-mode lines only.
  - 0x0C RAW, RO: synchronised post-polarity level.
  - 0x10 POLARITY, RW: 1 = active-low, so the line is inverted.
  - 0x14..0x1C: unmapped. Reads return 0, writes are ignored, and the access still completes.
- A write is any access with `wstrb != 0`. Byte lane n updates bits [8n+7:8n] only. PENDING W1C honours the strobes in the same way.
- Synchroniser: `SYNC_STAGES` flops per line. The active signal is `act = sync_out ^ POLARITY`. `act_q` is `act` delayed by one cycle.
- Level-mode line: `pending[i] <= act[i]` every cycle. A W1C write to such a line has no effect.
- Edge-mode line:
  - The set event is `act & ~act_q`.
  - If a set event and a W1C on the same bit land in the same cycle, set wins.
  - `pending` holds until it is cleared by W1C, or until the line's MODE is written to level.
- A POLARITY or MODE write changes `act` or behaviour from the next cycle. A polarity flip can create an edge on an edge-mode line; this is intended and documented for software.
- `irq_o = pending & ENABLE`, combinational from registers. ENABLE does not gate pending capture.
- Bus FSM has two states:
  - IDLE: `valid` high → capture the access, perform the write or latch `rdata`, go to RESP.
  - RESP: `ready` = 1 for exactly this cycle → return to IDLE.
- `valid` is ignored while in RESP. The master must hold `valid`, `addr`, `wdata` and `wstrb` stable until it sees `ready`.

## Timing
- Reset values:
  - ENABLE, MODE, PENDING, POLARITY, all sync flops and `act_q` = 0.
  - `ready` = 0, `rdata` = 0, `irq_o` = 0.
  - FSM in IDLE.
- Reset asserted mid-transaction aborts it: `ready` drops immediately (asynchronously) and no register write occurs after reset.
- Bus latency: `valid` sampled at edge k → `ready` and `rdata` valid during cycle k..k+1. Register writes take effect at edge k.
- Bus throughput: at most one access per 2 cycles; `ready` is never high two cycles in a row.
- `rdata` is held until the next read completes. Writes leave `rdata` unchanged.
- A read of PENDING in the same cycle as a set event returns the pre-set value. A read after a W1C returns the cleared value.
- Interrupt latency, with `SYNC_STAGES` = 2: an `irq_raw_i` change sampled at edge k → `pending` and `irq_o` change at edge k+2. Each extra sync stage adds one cycle.
- No width arithmetic; all operations are bitwise across 32 lanes.

## Test plan
- Reset: hold `rst_n_i` = 0 with random `irq_raw_i` → `irq_o` = 0, `ready` = 0; reads of all registers after release return 0.
- Level path:
  - Write ENABLE = 0x1, MODE = 0, then raise `irq_raw_i[0]` at edge k → `irq_o[0]` = 1 at edge k+2.
  - Drop the line → `irq_o[0]` = 0 two edges later.
  - A W1C to PENDING has no effect.
- Edge path:
  - Write MODE = 0x2, ENABLE = 0x2, then pulse `irq_raw_i[1]` for 1 cycle → `irq_o[1]` = 1 and stays set after the pulse.
  - Write 0x2 to PENDING → `irq_o[1]` = 0.
  - Write 0x1 to PENDING → no change to bit 1.
- Simultaneous set/clear: time the W1C of bit 1 to the cycle of a new rising edge → PENDING bit 1 remains 1.
- Polarity: write POLARITY = 0x4, MODE = 0, ENABLE = 0x4 with `irq_raw_i[2]` = 0 → `irq_o[2]` = 1 and RAW reads 0x4.
- Bus protocol:
  - Back-to-back writes with `valid` held high → `ready` pulses every second cycle.
  - A `wstrb` = 0x2 write of 0xFFFFFFFF to ENABLE → readback 0x0000FF00.
  - A read of 0x18 returns 0.
